mul_share_arbiter: RTL and testbench
====================================

Name: mul_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one radix-4 multiplier instance (8x8 unsigned, 16-bit product) between N_REQ requesters.
- Latches the winner's operands and drives the multiplier's reset/start/operand pins. The multiplier needs a reset pulse to clear `ready` and its iteration count, and its operands must stay stable throughout.
- Waits for the multiplier's `ready`, returns the product to the winner, and parks the multiplier in reset between jobs.
- Sits between the requesting datapath blocks and the single multiplier.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT, 63, max cycles in WAIT before the job is aborted with an error (1..255).

Ports:
- clock  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- req  in  N_REQ  level request per requester. Held high until its done pulse.
- x_bus  in  8*N_REQ  multiplicand lanes; lane i = bits [8i+7:8i].
- y_bus  in  8*N_REQ  multiplier lanes; lane i = bits [8i+7:8i].
- grant  out  N_REQ  one-hot owner of the multiplier. Held for the whole transaction.
- done  out  N_REQ  one-cycle one-hot completion pulse.
- result  out  16  product. Valid while done is high, held until the next completion.
- err  out  1  high with done when the job timed out.
- busy  out  1  high from LAUNCH through DONE.
- mul_reset  out  1  drives the multiplier's reset.
- mul_start  out  1  drives the multiplier's start.
- mul_x  out  8  drives the multiplier's x_value.
- mul_y  out  8  drives the multiplier's y_value.
- mul_product  in  16  the multiplier's total_product.
- mul_ready  in  1  the multiplier's ready.

Behaviour:
- All outputs are registered.
- Reset values: grant=0, done=0, result=0, err=0, busy=0, mul_reset=1, mul_start=0, mul_x=0, mul_y=0, state=IDLE, rr_ptr=0, wait_cnt=0.
- Reset asserted in any state (including mid-WAIT) forces these values on the next edge. The in-flight job is dropped with no done pulse.
- States: IDLE, LAUNCH, WAIT, DONE (2-bit encoding).
- Round-robin arbitration:
  - In IDLE, search req starting at index rr_ptr, wrapping modulo N_REQ. The first set bit wins.
  - rr_ptr is updated to winner+1 (mod N_REQ) on entry to DONE.
  - With req=0, stay in IDLE and keep mul_reset=1.
- IDLE -> LAUNCH (winner found at edge T):
  - At T+1: grant=onehot(winner), busy=1, mul_x/mul_y = winner's lanes, mul_reset=0, mul_start=1, wait_cnt=0.
  - mul_x and mul_y stay frozen until the return to IDLE; later changes on x_bus/y_bus are ignored.
- LAUNCH -> WAIT: mul_start=0 on the next edge. Exactly one start cycle.
- WAIT:
  - wait_cnt increments each cycle.
  - If mul_ready=1 is sampled: result<=mul_product, err<=0, done<=grant, mul_reset<=1, go to DONE.
  - Else if wait_cnt==TIMEOUT: result<=0, err<=1, done<=grant, mul_reset<=1, go to DONE.
  - If mul_ready and the timeout occur in the same cycle, mul_ready wins.
- DONE (one cycle, done visible):
  - Next edge: done=0, grant=0, busy=0, go to IDLE.
  - err and result hold until the next completion.
- Latency: grant 1 cycle after req is sampled in IDLE. done = 1 (LAUNCH) + multiplier cycles + 1 after grant.
- Back-to-back: IDLE re-arbitrates on the cycle after DONE.
- A requester must deassert req in the cycle its done is high. A req still high in the following IDLE is treated as a new job.
- req dropping mid-transaction does not abort the job; done is still pulsed.
- mul_product is 16 bits and passed through unchanged; no widening or truncation.
- grant and done are never multi-hot.

Test Plan:
- Single job: req=0001, lane0 x=7, y=9 -> grant=0001 one cycle later, mul_start high exactly 1 cycle, done=0001 with result=63, err=0; busy low after DONE.
- Max operands: lane2 x=255, y=255 -> result=65025 (0xFE01), done=0100, mul_x/mul_y stable at 0xFF through WAIT while x_bus lane 2 toggles.
- Round-robin: req=1111 held and each requester drops after its done -> grants 0001, 0010, 0100, 1000. Then req=1001 -> grant 0001 (rr_ptr wrapped to 0).
- Fairness: after a job on requester 1, req=0011 -> grant 0010 is NOT given first; grant=0001 wait, rr_ptr=2 so search 2,3,0 -> grant 0001.
- Timeout: mul_ready tied 0 -> done pulsed after exactly TIMEOUT+1 WAIT cycles with err=1, result=0, mul_reset=1; next job (x=3, y=5) completes normally with err=0, result=15.
- Reset mid-WAIT: assert reset for 1 cycle during WAIT -> next edge all outputs at reset values (mul_reset=1, grant=0), no done pulse; the re-issued request completes correctly.

Source files
------------

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter
//   Round-robin arbiter and sequencer that shares one 8x8 radix-4 multiplier
//   between N_REQ requesters. The winner's operands are latched, the
//   multiplier is released from reset and started for one cycle, and the
//   product (or a timeout error) is returned to the winner with a one-cycle
//   done pulse. The multiplier is parked in reset between jobs.
//
// Ports
//   clock        system clock, all logic on posedge
//   reset        synchronous, active-high
//   req          level request per requester, held until its done pulse
//   x_bus/y_bus  operand lanes, lane i = bits [8i+7:8i]
//   grant        one-hot owner of the multiplier for the whole transaction
//   done         one-cycle one-hot completion pulse
//   result       product, held until the next completion
//   err          set with done when the job timed out
//   busy         high from LAUNCH through DONE
//   mul_reset    multiplier reset
//   mul_start    multiplier start
//   mul_x/mul_y  multiplier operands, frozen for the whole job
//   mul_product  multiplier total_product
//   mul_ready    multiplier ready
module mul_share_arbiter #(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned TIMEOUT = 63
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [N_REQ-1:0]     req,
   input  logic [8*N_REQ-1:0]   x_bus,
   input  logic [8*N_REQ-1:0]   y_bus,
   output logic [N_REQ-1:0]     grant,
   output logic [N_REQ-1:0]     done,
   output logic [15:0]          result,
   output logic                 err,
   output logic                 busy,
   output logic                 mul_reset,
   output logic                 mul_start,
   output logic [7:0]           mul_x,
   output logic [7:0]           mul_y,
   input  logic [15:0]          mul_product,
   input  logic                 mul_ready
);

   localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t           state;
   logic [PW-1:0]    rr_ptr;
   logic [PW-1:0]    owner;
   logic [7:0]       wait_cnt;

   logic             found;
   logic [PW-1:0]    win_idx;
   logic [7:0]       win_x;
   logic [7:0]       win_y;
   logic [N_REQ-1:0] win_onehot;
   logic [PW-1:0]    rr_next;

   // Search req starting at rr_ptr, wrapping modulo N_REQ; first set bit wins.
   always_comb begin
      int unsigned idx;
      idx     = 0;
      found   = 1'b0;
      win_idx = '0;
      win_x   = '0;
      win_y   = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         idx = (32'(rr_ptr) + k) % N_REQ;
         if (!found && req[idx]) begin
            found   = 1'b1;
            win_idx = PW'(idx);
            win_x   = x_bus[8*idx +: 8];
            win_y   = y_bus[8*idx +: 8];
         end
      end
   end

   assign win_onehot = N_REQ'(1) << win_idx;
   assign rr_next    = (owner == PW'(N_REQ - 1)) ? '0 : owner + PW'(1);

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         owner     <= '0;
         wait_cnt  <= '0;
         grant     <= '0;
         done      <= '0;
         result    <= '0;
         err       <= 1'b0;
         busy      <= 1'b0;
         mul_reset <= 1'b1;
         mul_start <= 1'b0;
         mul_x     <= '0;
         mul_y     <= '0;
      end else begin
         case (state)
            IDLE: begin
               mul_reset <= 1'b1;
               if (found) begin
                  state     <= LAUNCH;
                  grant     <= win_onehot;
                  owner     <= win_idx;
                  busy      <= 1'b1;
                  mul_x     <= win_x;
                  mul_y     <= win_y;
                  mul_reset <= 1'b0;
                  mul_start <= 1'b1;
                  wait_cnt  <= '0;
               end
            end
            LAUNCH: begin
               mul_start <= 1'b0;
               state     <= WAIT;
            end
            WAIT: begin
               wait_cnt <= wait_cnt + 8'd1;
               // ready has priority over a timeout landing in the same cycle
               if (mul_ready) begin
                  result    <= mul_product;
                  err       <= 1'b0;
                  done      <= grant;
                  mul_reset <= 1'b1;
                  rr_ptr    <= rr_next;
                  state     <= DONE;
               end else if (wait_cnt == 8'(TIMEOUT)) begin
                  result    <= '0;
                  err       <= 1'b1;
                  done      <= grant;
                  mul_reset <= 1'b1;
                  rr_ptr    <= rr_next;
                  state     <= DONE;
               end
            end
            DONE: begin
               done  <= '0;
               grant <= '0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter
//   Self-checking bench for mul_share_arbiter: a behavioural multiplier with a
//   programmable ready latency (0 = never ready) drives the DUT, and a job-level
//   reference model predicts winner, product, error flag and completion time.
module tb_mul_share_arbiter;

   localparam int N  = 4;
   localparam int TO = 12;

   logic            clock = 1'b0;
   logic            reset;
   logic [N-1:0]    req;
   logic [8*N-1:0]  x_bus;
   logic [8*N-1:0]  y_bus;
   logic [N-1:0]    grant;
   logic [N-1:0]    done;
   logic [15:0]     result;
   logic            err;
   logic            busy;
   logic            mul_reset;
   logic            mul_start;
   logic [7:0]      mul_x;
   logic [7:0]      mul_y;
   logic [15:0]     mul_product;
   logic            mul_ready;

   mul_share_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
      .clock       (clock),
      .reset       (reset),
      .req         (req),
      .x_bus       (x_bus),
      .y_bus       (y_bus),
      .grant       (grant),
      .done        (done),
      .result      (result),
      .err         (err),
      .busy        (busy),
      .mul_reset   (mul_reset),
      .mul_start   (mul_start),
      .mul_x       (mul_x),
      .mul_y       (mul_y),
      .mul_product (mul_product),
      .mul_ready   (mul_ready)
   );

   always #5 clock = ~clock;

   // Behavioural multiplier: ready rises lat edges after start is sampled.
   int          lat = 1;
   logic        m_armed;
   int          m_cnt;
   logic        m_ready;
   logic [15:0] m_prod;

   always @(posedge clock) begin
      if (mul_reset) begin
         m_armed <= 1'b0;
         m_cnt   <= 0;
         m_ready <= 1'b0;
         m_prod  <= 16'hDEAD;
      end else if (mul_start) begin
         m_armed <= 1'b1;
         m_cnt   <= 1;
         if (lat == 1) begin
            m_ready <= 1'b1;
            m_prod  <= 16'(mul_x) * 16'(mul_y);
         end
      end else if (m_armed && !m_ready) begin
         m_cnt <= m_cnt + 1;
         if (lat != 0 && m_cnt + 1 == lat) begin
            m_ready <= 1'b1;
            m_prod  <= 16'(mul_x) * 16'(mul_y);
         end
      end
   end

   assign mul_ready   = m_ready;
   assign mul_product = m_prod;

   int checks   = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, expv);
      end
   endtask

   // Reference model state
   int          rr;
   logic [15:0] last_res;
   logic        last_err;
   logic [N-1:0] pending;

   function automatic int pick(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++) begin
         if (r[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   task automatic check_reset_values();
      check_eq("rst_grant", grant, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_result", result, 0);
      check_eq("rst_err", err, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_mul_reset", mul_reset, 1);
      check_eq("rst_mul_start", mul_start, 0);
      check_eq("rst_mul_x", mul_x, 0);
      check_eq("rst_mul_y", mul_y, 0);
   endtask

   // Called at a negedge with the DUT in IDLE; returns at the negedge after
   // the DONE cycle (DUT back in IDLE).
   task automatic do_job(input int l, input bit grow);
      int          w;
      int          n;
      int          exp_n;
      logic [7:0]  ex;
      logic [7:0]  ey;
      logic [N-1:0] g;
      logic [15:0] exp_res;
      logic        exp_err;
      lat = l;
      if (pending == 0) pending = N'($urandom_range(1, (1 << N) - 1));
      req = pending;
      w   = pick(pending, rr);
      ex  = x_bus[8*w +: 8];
      ey  = y_bus[8*w +: 8];
      g   = N'(1) << w;
      if (l != 0 && l <= TO + 1) begin
         exp_n = l + 1; exp_res = 16'(ex) * 16'(ey); exp_err = 1'b0;
      end else begin
         exp_n = TO + 2; exp_res = 16'h0; exp_err = 1'b1;
      end

      @(negedge clock);
      check_eq("launch_grant", grant, g);
      check_eq("launch_busy", busy, 1);
      check_eq("launch_start", mul_start, 1);
      check_eq("launch_mul_reset", mul_reset, 0);
      check_eq("launch_mul_x", mul_x, ex);
      check_eq("launch_mul_y", mul_y, ey);
      check_eq("launch_done", done, 0);
      check_eq("launch_result_held", result, last_res);
      check_eq("launch_err_held", err, last_err);

      n = 0;
      while (n < TO + 5) begin
         @(negedge clock);
         n++;
         x_bus = (8*N)'($urandom);
         y_bus = (8*N)'($urandom);
         if (done != 0) break;
         check_eq("wait_start", mul_start, 0);
         check_eq("wait_grant", grant, g);
         check_eq("wait_mul_x", mul_x, ex);
         check_eq("wait_mul_y", mul_y, ey);
         check_eq("wait_mul_reset", mul_reset, 0);
      end
      check_eq("done_pulse", done, g);
      check_eq("done_latency", n, exp_n);
      check_eq("done_result", result, exp_res);
      check_eq("done_err", err, exp_err);
      check_eq("done_mul_reset", mul_reset, 1);
      check_eq("done_grant", grant, g);
      check_eq("done_busy", busy, 1);

      rr         = (w + 1) % N;
      last_res   = exp_res;
      last_err   = exp_err;
      pending[w] = 1'b0;
      if (grow) pending |= N'($urandom) & N'($urandom);
      req = pending;

      @(negedge clock);
      check_eq("idle_done", done, 0);
      check_eq("idle_grant", grant, 0);
      check_eq("idle_busy", busy, 0);
      check_eq("idle_mul_reset", mul_reset, 1);
      check_eq("idle_start", mul_start, 0);
      check_eq("idle_result_held", result, last_res);
      check_eq("idle_err_held", err, last_err);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      reset    = 1'b1;
      req      = '0;
      x_bus    = '0;
      y_bus    = '0;
      rr       = 0;
      last_res = '0;
      last_err = 1'b0;
      pending  = '0;
      repeat (3) @(negedge clock);
      check_reset_values();
      reset = 1'b0;
      @(negedge clock);
      check_eq("noreq_grant", grant, 0);
      check_eq("noreq_mul_reset", mul_reset, 1);
      check_eq("noreq_busy", busy, 0);

      // single job, lane 0: 7*9
      x_bus[7:0] = 8'd7; y_bus[7:0] = 8'd9;
      pending = 4'b0001;
      do_job(3, 1'b0);
      check_eq("single_result", result, 63);

      // max operands on lane 2
      x_bus[23:16] = 8'hFF; y_bus[23:16] = 8'hFF;
      pending = 4'b0100;
      do_job(5, 1'b0);
      check_eq("max_result", result, 16'hFE01);

      // bring rr_ptr back to 0, then full round robin
      pending = 4'b1000;
      do_job(2, 1'b0);
      pending = 4'b1111;
      for (int i = 0; i < N; i++) do_job($urandom_range(1, 6), 1'b0);
      pending = 4'b1001;
      do_job(2, 1'b0);

      // fairness: after requester 1 is served, 0011 goes to requester 0
      pending = 4'b0010;
      do_job(2, 1'b0);
      pending = 4'b0011;
      do_job(3, 1'b0);
      check_eq("fair_rr", rr, 1);
      pending = 4'b0000;
      req = pending;

      // timeout then normal job
      pending = 4'b0001;
      do_job(0, 1'b0);
      x_bus[15:8] = 8'd3; y_bus[15:8] = 8'd5;
      pending = 4'b0010;
      do_job(4, 1'b0);
      check_eq("post_timeout_result", result, 15);

      // ready on the last allowed cycle wins; one later times out
      pending = 4'b0100;
      do_job(TO + 1, 1'b0);
      pending = 4'b1000;
      do_job(TO + 2, 1'b0);

      // randomized jobs with overlapping requests
      x_bus = (8*N)'($urandom);
      y_bus = (8*N)'($urandom);
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 9) == 0) do_job(0, 1'b1);
         else                           do_job($urandom_range(1, TO + 2), 1'b1);
      end

      // reset in the middle of WAIT drops the job
      pending = 4'b0100;
      x_bus[23:16] = 8'd11; y_bus[23:16] = 8'd13;
      req  = pending;
      lat  = 0;
      @(negedge clock);
      check_eq("rstw_grant", grant, 4'b0100);
      repeat (3) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check_reset_values();
      reset    = 1'b0;
      rr       = 0;
      last_res = '0;
      last_err = 1'b0;
      do_job(4, 1'b0);
      check_eq("rstw_result", result, 143);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
